// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU sequencer and its register file.
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int REG_N  = 4;
  localparam int ADDR_W = 2;
  localparam int CNT_W  = 4;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_XOR = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_CSL = 3'd3;
  localparam logic [2:0] OP_LDI = 3'd4;
  localparam logic [2:0] OP_RD  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Opcodes 0..3 go through the external ALU; their low bits are the ALU select.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// 4x8 register file: two combinational read ports, one synchronous write port,
// cleared by the synchronous reset.
module seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_i,
  input  logic [ADDR_W-1:0] rb_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] regs_q [REG_N];

  // Storage update: clear everything on reset, otherwise a single write per edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign a_o = regs_q[ra_i];
  assign b_o = regs_q[rb_i];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for an external combinational 8-bit ALU.
// Handshake: a command transfers on a rising edge where CmdValid and CmdReady
// are both high; CmdReady depends only on the FSM state (high in IDLE), never
// on CmdValid, and command fields are only sampled on that transfer edge.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ALU_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [2:0]        CmdOp,
  input  logic [ADDR_W-1:0] CmdRd,
  input  logic [ADDR_W-1:0] CmdRa,
  input  logic [ADDR_W-1:0] CmdRb,
  input  logic [DATA_W-1:0] CmdImm,
  input  logic [CNT_W-1:0]  CmdRep,
  output logic [DATA_W-1:0] ALUinA,
  output logic [DATA_W-1:0] ALUinB,
  output logic [1:0]        InsSel,
  input  logic [DATA_W-1:0] ALUout,
  input  logic              CO,
  input  logic              Z,
  output logic              DoneValid,
  output logic [DATA_W-1:0] Result,
  output logic              FlagC,
  output logic              FlagZ,
  output logic              Err,
  output logic              Busy,
  output state_e            DbgState
);

  // Settle counter restarts here so each ALU evaluation is held ALU_WAIT cycles.
  localparam logic [CNT_W-1:0] WAIT_RELOAD = CNT_W'(ALU_WAIT - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, result_q;
  logic [1:0]        ins_sel_q;
  logic [ADDR_W-1:0] rd_q;
  logic [CNT_W-1:0]  rep_q, wait_q;
  logic              flag_c_q, flag_z_q, err_q;

  logic [DATA_W-1:0] rf_a, rf_b, rf_wd;
  logic [ADDR_W-1:0] rf_wa;
  logic              rf_we;

  logic accept, is_alu, is_ldi, is_rd, is_bad, wb_fire, last_fire;

  assign accept    = CmdValid && (state_q == IDLE);
  assign is_alu    = is_alu_op(CmdOp);
  assign is_ldi    = (CmdOp == OP_LDI);
  assign is_rd     = (CmdOp == OP_RD);
  assign is_bad    = CmdOp[2] && CmdOp[1];
  // Write-back happens once the settle counter has run out for this iteration.
  assign wb_fire   = (state_q == EXEC) && (wait_q == '0);
  assign last_fire = wb_fire && (rep_q == '0);

  seq_regfile u_regfile (
    .clk  (clk),
    .rst  (rst),
    .ra_i (CmdRa),
    .rb_i (CmdRb),
    .a_o  (rf_a),
    .b_o  (rf_b),
    .we_i (rf_we),
    .wa_i (rf_wa),
    .wd_i (rf_wd)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: ALU ops run through EXEC, everything else goes straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = is_alu ? EXEC : DONE;
        end
      end
      EXEC: begin
        if (last_fire) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register-file write select: ALU write-back in EXEC, immediate load on accept.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = CmdRd;
    rf_wd = CmdImm;
    if (wb_fire) begin
      rf_we = 1'b1;
      rf_wa = rd_q;
      rf_wd = ALUout;
    end else if (accept && is_ldi) begin
      rf_we = 1'b1;
    end
  end

  // Datapath: operand capture, settle counting, iteration chaining, flags and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      ins_sel_q <= '0;
      rd_q      <= '0;
      rep_q     <= '0;
      wait_q    <= '0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      err_q <= is_bad;
      if (is_alu) begin
        alu_a_q   <= rf_a;
        alu_b_q   <= rf_b;
        ins_sel_q <= CmdOp[1:0];
        rd_q      <= CmdRd;
        rep_q     <= CmdRep;
        wait_q    <= WAIT_RELOAD;
      end
      if (is_ldi) begin
        flag_z_q <= (CmdImm == '0);
        result_q <= CmdImm;
      end
      if (is_rd) begin
        result_q <= rf_a;
      end
    end else if (state_q == EXEC) begin
      if (wait_q != '0) begin
        wait_q <= wait_q - CNT_W'(1);
      end else begin
        flag_c_q <= CO;
        flag_z_q <= Z;
        result_q <= ALUout;
        // B stays as captured so a destination aliasing Rb does not disturb later iterations.
        if (rep_q != '0) begin
          alu_a_q <= ALUout;
          rep_q   <= rep_q - CNT_W'(1);
          wait_q  <= WAIT_RELOAD;
        end
      end
    end
  end

  assign CmdReady  = (state_q == IDLE);
  assign Busy      = (state_q != IDLE);
  assign DoneValid = (state_q == DONE);
  assign Err       = (state_q == DONE) && err_q;
  assign ALUinA    = alu_a_q;
  assign ALUinB    = alu_b_q;
  assign InsSel    = ins_sel_q;
  assign Result    = result_q;
  assign FlagC     = flag_c_q;
  assign FlagZ     = flag_z_q;
  assign DbgState  = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (ALU_WAIT=1 and ALU_WAIT=3), each with
// its own combinational ALU model, checked against a command-level reference.
module tb_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [2:0] cmd_op [2];
  logic [1:0] cmd_rd [2];
  logic [1:0] cmd_ra [2];
  logic [1:0] cmd_rb [2];
  logic [7:0] cmd_imm [2];
  logic [3:0] cmd_rep [2];
  logic [7:0] alu_a [2];
  logic [7:0] alu_b [2];
  logic [1:0] ins_sel [2];
  logic [7:0] alu_out [2];
  logic       alu_co [2];
  logic       alu_z [2];
  logic       done_valid [2];
  logic [7:0] result [2];
  logic       flag_c [2];
  logic       flag_z [2];
  logic       err [2];
  logic       busy [2];
  logic [1:0] dbg_state [2];

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         u;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] imm;
    logic [3:0] rep;
  } cmd_t;

  // Reference state: register file and flags per unit.
  logic [7:0] m_r [2][4];
  logic       m_c [2];
  logic       m_z [2];
  logic [7:0] a_trace [$];

  // The ALU that sits beside the sequencer: {carry, result}.
  function automatic logic [8:0] alu_fn(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b);
    case (sel)
      2'd0:    return {1'b0, a & b};
      2'd1:    return {1'b0, a ^ b};
      2'd2:    return {1'b0, a} + {1'b0, b};
      default: return {a[7], a[6:0], a[7]};
    endcase
  endfunction

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      {alu_co[k], alu_out[k]} = alu_fn(ins_sel[k], alu_a[k], alu_b[k]);
      alu_z[k] = ((alu_fn(ins_sel[k], alu_a[k], alu_b[k]) & 9'h0FF) == 9'h000);
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_sequencer #(.ALU_WAIT(g == 0 ? 1 : 3)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .CmdValid  (cmd_valid[g]),
      .CmdReady  (cmd_ready[g]),
      .CmdOp     (cmd_op[g]),
      .CmdRd     (cmd_rd[g]),
      .CmdRa     (cmd_ra[g]),
      .CmdRb     (cmd_rb[g]),
      .CmdImm    (cmd_imm[g]),
      .CmdRep    (cmd_rep[g]),
      .ALUinA    (alu_a[g]),
      .ALUinB    (alu_b[g]),
      .InsSel    (ins_sel[g]),
      .ALUout    (alu_out[g]),
      .CO        (alu_co[g]),
      .Z         (alu_z[g]),
      .DoneValid (done_valid[g]),
      .Result    (result[g]),
      .FlagC     (flag_c[g]),
      .FlagZ     (flag_z[g]),
      .Err       (err[g]),
      .Busy      (busy[g]),
      .DbgState  (dbg_state[g])
    );
  end

  function automatic int wait_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic cmd_t mk(input int u, input logic [2:0] op, input logic [1:0] rd,
                              input logic [1:0] ra, input logic [1:0] rb,
                              input logic [7:0] imm, input logic [3:0] rep);
    cmd_t c;
    c.u = u; c.op = op; c.rd = rd; c.ra = ra; c.rb = rb; c.imm = imm; c.rep = rep;
    return c;
  endfunction

  task automatic model_reset(input int u);
    for (int i = 0; i < 4; i++) m_r[u][i] = 8'h00;
    m_c[u] = 1'b0;
    m_z[u] = 1'b0;
  endtask

  // Command-level reference: expected latency (edges after accept), result, error.
  task automatic model_cmd(input cmd_t c, output int lat, output logic [7:0] res, output logic e);
    logic [7:0] a, b, o;
    logic [8:0] t;
    lat = 0; res = 8'h00; e = 1'b0;
    if (c.op <= 3'd3) begin
      a = m_r[c.u][c.ra];
      b = m_r[c.u][c.rb];
      o = a;
      for (int i = 0; i <= int'(c.rep); i++) begin
        t = alu_fn(c.op[1:0], a, b);
        o = t[7:0];
        m_c[c.u] = t[8];
        a = o;
      end
      m_r[c.u][c.rd] = o;
      m_z[c.u] = (o == 8'h00);
      res = o;
      lat = wait_of(c.u) * (int'(c.rep) + 1);
    end else if (c.op == 3'd4) begin
      m_r[c.u][c.rd] = c.imm;
      m_z[c.u] = (c.imm == 8'h00);
      res = c.imm;
    end else if (c.op == 3'd5) begin
      res = m_r[c.u][c.ra];
    end else begin
      e = 1'b1;
    end
  endtask

  // Driver: present a command, wait for the accept edge, then measure the
  // DoneValid latency and capture the completion outputs.
  task automatic run_cmd(input cmd_t c, output int lat, output logic [7:0] res,
                         output logic fc, output logic fz, output logic fe, output logic pulse);
    int n;
    @(negedge clk);
    cmd_op[c.u] = c.op; cmd_rd[c.u] = c.rd; cmd_ra[c.u] = c.ra; cmd_rb[c.u] = c.rb;
    cmd_imm[c.u] = c.imm; cmd_rep[c.u] = c.rep; cmd_valid[c.u] = 1'b1;
    n = 0;
    while (!cmd_ready[c.u] && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (cmd_ready[c.u] !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_wait u%0d: CmdReady=%b required 1", c.u, cmd_ready[c.u]);
    end
    @(posedge clk);
    #1;
    cmd_valid[c.u] = 1'b0;
    cmd_op[c.u] = 3'($urandom); cmd_rd[c.u] = 2'($urandom); cmd_ra[c.u] = 2'($urandom);
    cmd_rb[c.u] = 2'($urandom); cmd_imm[c.u] = 8'($urandom); cmd_rep[c.u] = 4'($urandom);
    a_trace.delete();
    n = 0;
    @(negedge clk);
    a_trace.push_back(alu_a[c.u]);
    while (!done_valid[c.u] && n < 200) begin
      @(negedge clk);
      n++;
      a_trace.push_back(alu_a[c.u]);
    end
    lat = n; res = result[c.u]; fc = flag_c[c.u]; fz = flag_z[c.u]; fe = err[c.u];
    @(negedge clk);
    pulse = !done_valid[c.u];
  endtask

  task automatic test_reset();
    cmd_t c;
    int lat, xl;
    logic [7:0] res, xr;
    logic fc, fz, fe, pl, xe;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; cmd_valid[k] = 1'b1; cmd_op[k] = 3'd4; cmd_rd[k] = 2'd0; cmd_imm[k] = 8'hAA;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++; if (done_valid[k] !== 1'b0) begin miscompares++; $display("FAIL rst_done u%0d: got %b required 0", k, done_valid[k]); end
      vectors++; if (cmd_ready[k] !== 1'b1) begin miscompares++; $display("FAIL rst_ready u%0d: got %b required 1", k, cmd_ready[k]); end
      vectors++; if (busy[k] !== 1'b0) begin miscompares++; $display("FAIL rst_busy u%0d: got %b required 0", k, busy[k]); end
      vectors++; if ({alu_a[k], alu_b[k], ins_sel[k]} !== 18'h0) begin miscompares++; $display("FAIL rst_alu_in u%0d: got %h/%h/%h required 0", k, alu_a[k], alu_b[k], ins_sel[k]); end
      vectors++; if (result[k] !== 8'h00) begin miscompares++; $display("FAIL rst_result u%0d: got %h required 00", k, result[k]); end
      vectors++; if ({flag_c[k], flag_z[k], err[k]} !== 3'b000) begin miscompares++; $display("FAIL rst_flags u%0d: got %b required 000", k, {flag_c[k], flag_z[k], err[k]}); end
    end
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; cmd_valid[k] = 1'b0; model_reset(k);
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++; if (cmd_ready[k] !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready u%0d: got %b required 1", k, cmd_ready[k]); end
    end
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 4; r++) begin
        c = mk(k, 3'd5, 2'd0, 2'(r), 2'd0, 8'h00, 4'd0);
        model_cmd(c, xl, xr, xe);
        run_cmd(c, lat, res, fc, fz, fe, pl);
        vectors++; if (res !== xr) begin miscompares++; $display("FAIL rst_reg u%0d r%0d: got %h required %h", k, r, res, xr); end
      end
    end
  endtask

  task automatic test_directed();
    cmd_t tbl [$];
    int lat, xl;
    logic [7:0] res, xr;
    logic fc, fz, fe, pl, xe;
    tbl.push_back(mk(0, 3'd4, 2'd0, 2'd0, 2'd0, 8'h61, 4'd0));
    tbl.push_back(mk(0, 3'd4, 2'd1, 2'd0, 2'd0, 8'h95, 4'd0));
    tbl.push_back(mk(0, 3'd0, 2'd2, 2'd0, 2'd1, 8'h00, 4'd0));
    tbl.push_back(mk(0, 3'd4, 2'd0, 2'd0, 2'd0, 8'h29, 4'd0));
    tbl.push_back(mk(0, 3'd4, 2'd1, 2'd0, 2'd0, 8'h81, 4'd0));
    tbl.push_back(mk(0, 3'd1, 2'd2, 2'd0, 2'd1, 8'h00, 4'd0));
    tbl.push_back(mk(0, 3'd1, 2'd3, 2'd2, 2'd2, 8'h00, 4'd0));
    tbl.push_back(mk(0, 3'd4, 2'd0, 2'd0, 2'd0, 8'h61, 4'd0));
    tbl.push_back(mk(0, 3'd4, 2'd1, 2'd0, 2'd0, 8'h67, 4'd0));
    tbl.push_back(mk(0, 3'd2, 2'd2, 2'd0, 2'd1, 8'h00, 4'd0));
    tbl.push_back(mk(0, 3'd4, 2'd0, 2'd0, 2'd0, 8'hFF, 4'd0));
    tbl.push_back(mk(0, 3'd4, 2'd1, 2'd0, 2'd0, 8'h01, 4'd0));
    tbl.push_back(mk(0, 3'd2, 2'd2, 2'd0, 2'd1, 8'h00, 4'd0));
    tbl.push_back(mk(0, 3'd4, 2'd0, 2'd0, 2'd0, 8'h03, 4'd0));
    tbl.push_back(mk(0, 3'd4, 2'd1, 2'd0, 2'd0, 8'h05, 4'd0));
    tbl.push_back(mk(0, 3'd2, 2'd1, 2'd0, 2'd1, 8'h00, 4'd2));
    tbl.push_back(mk(0, 3'd5, 2'd0, 2'd1, 2'd0, 8'h00, 4'd9));
    tbl.push_back(mk(1, 3'd4, 2'd2, 2'd0, 2'd0, 8'hC9, 4'd0));
    tbl.push_back(mk(1, 3'd3, 2'd2, 2'd2, 2'd2, 8'h00, 4'd7));
    tbl.push_back(mk(1, 3'd4, 2'd1, 2'd0, 2'd0, 8'h00, 4'd5));
    tbl.push_back(mk(1, 3'd2, 2'd3, 2'd2, 2'd2, 8'h00, 4'd1));
    foreach (tbl[i]) begin
      model_cmd(tbl[i], xl, xr, xe);
      run_cmd(tbl[i], lat, res, fc, fz, fe, pl);
      vectors++; if (lat !== xl) begin miscompares++; $display("FAIL dir_latency[%0d]: got %0d required %0d", i, lat, xl); end
      vectors++; if (fe !== xe) begin miscompares++; $display("FAIL dir_err[%0d]: got %b required %b", i, fe, xe); end
      vectors++; if (res !== xr) begin miscompares++; $display("FAIL dir_result[%0d]: got %h required %h", i, res, xr); end
      vectors++; if (fc !== m_c[tbl[i].u]) begin miscompares++; $display("FAIL dir_flagc[%0d]: got %b required %b", i, fc, m_c[tbl[i].u]); end
      vectors++; if (fz !== m_z[tbl[i].u]) begin miscompares++; $display("FAIL dir_flagz[%0d]: got %b required %b", i, fz, m_z[tbl[i].u]); end
      vectors++; if (pl !== 1'b1) begin miscompares++; $display("FAIL dir_pulse[%0d]: DoneValid still high next cycle", i); end
    end
  endtask

  task automatic test_csl_trace();
    logic [7:0] exp_a [3];
    cmd_t c;
    int lat, xl;
    logic [7:0] res, xr;
    logic fc, fz, fe, pl, xe;
    exp_a[0] = 8'hC9; exp_a[1] = 8'h93; exp_a[2] = 8'h27;
    c = mk(0, 3'd4, 2'd0, 2'd0, 2'd0, 8'hC9, 4'd0);
    model_cmd(c, xl, xr, xe);
    run_cmd(c, lat, res, fc, fz, fe, pl);
    c = mk(0, 3'd3, 2'd1, 2'd0, 2'd0, 8'h00, 4'd2);
    model_cmd(c, xl, xr, xe);
    run_cmd(c, lat, res, fc, fz, fe, pl);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (a_trace[i] !== exp_a[i]) begin miscompares++; $display("FAIL csl_alu_a[%0d]: got %h required %h", i, a_trace[i], exp_a[i]); end
    end
    vectors++; if (res !== xr) begin miscompares++; $display("FAIL csl_result: got %h required %h", res, xr); end
    vectors++; if (lat !== xl) begin miscompares++; $display("FAIL csl_latency: got %0d required %0d", lat, xl); end
  endtask

  task automatic test_illegal();
    cmd_t c;
    int lat, xl;
    logic [7:0] res, xr;
    logic fc, fz, fe, pl, xe;
    for (int r = 0; r < 4; r++) begin
      c = mk(0, 3'd4, 2'(r), 2'd0, 2'd0, 8'(8'h11 * (r + 1)), 4'd0);
      model_cmd(c, xl, xr, xe);
      run_cmd(c, lat, res, fc, fz, fe, pl);
    end
    for (int k = 6; k < 8; k++) begin
      c = mk(0, 3'(k), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), 4'($urandom));
      model_cmd(c, xl, xr, xe);
      run_cmd(c, lat, res, fc, fz, fe, pl);
      vectors++; if (fe !== 1'b1) begin miscompares++; $display("FAIL ill_err op%0d: got %b required 1", k, fe); end
      vectors++; if (lat !== xl) begin miscompares++; $display("FAIL ill_latency op%0d: got %0d required %0d", k, lat, xl); end
      vectors++; if ({fc, fz} !== {m_c[0], m_z[0]}) begin miscompares++; $display("FAIL ill_flags op%0d: got %b required %b", k, {fc, fz}, {m_c[0], m_z[0]}); end
    end
    for (int r = 0; r < 4; r++) begin
      c = mk(0, 3'd5, 2'd0, 2'(r), 2'd0, 8'h00, 4'd0);
      model_cmd(c, xl, xr, xe);
      run_cmd(c, lat, res, fc, fz, fe, pl);
      vectors++; if (res !== xr) begin miscompares++; $display("FAIL ill_reg r%0d: got %h required %h", r, res, xr); end
      vectors++; if (fe !== 1'b0) begin miscompares++; $display("FAIL rd_err r%0d: got %b required 0", r, fe); end
    end
  endtask

  task automatic test_backpressure();
    cmd_t c;
    int lat, xl, accepts, dones, bad_busy;
    logic [7:0] res, xr;
    logic fc, fz, fe, pl, xe;
    c = mk(0, 3'd4, 2'd0, 2'd0, 2'd0, 8'h00, 4'd0);
    model_cmd(c, xl, xr, xe);
    run_cmd(c, lat, res, fc, fz, fe, pl);
    c = mk(0, 3'd4, 2'd1, 2'd0, 2'd0, 8'h01, 4'd0);
    model_cmd(c, xl, xr, xe);
    run_cmd(c, lat, res, fc, fz, fe, pl);
    c = mk(0, 3'd2, 2'd0, 2'd0, 2'd1, 8'h00, 4'd0);
    accepts = 0; dones = 0; bad_busy = 0;
    @(negedge clk);
    cmd_op[0] = c.op; cmd_rd[0] = c.rd; cmd_ra[0] = c.ra; cmd_rb[0] = c.rb;
    cmd_imm[0] = c.imm; cmd_rep[0] = c.rep; cmd_valid[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 39) cmd_valid[0] = 1'b0;
      else if (cmd_ready[0]) accepts++;
      if (done_valid[0]) dones++;
      if (busy[0] === cmd_ready[0]) bad_busy++;
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      if (done_valid[0]) dones++;
      @(negedge clk);
    end
    // IDLE + one EXEC cycle + DONE per command with ALU_WAIT=1, over 39 held cycles.
    vectors++; if (accepts !== 13) begin miscompares++; $display("FAIL bp_accepts: got %0d required 13", accepts); end
    vectors++; if (dones !== accepts) begin miscompares++; $display("FAIL bp_dones: got %0d required %0d", dones, accepts); end
    vectors++; if (bad_busy !== 0) begin miscompares++; $display("FAIL bp_busy: %0d cycles with Busy==CmdReady, required 0", bad_busy); end
    for (int i = 0; i < accepts; i++) model_cmd(c, xl, xr, xe);
    c = mk(0, 3'd5, 2'd0, 2'd0, 2'd0, 8'h00, 4'd0);
    model_cmd(c, xl, xr, xe);
    run_cmd(c, lat, res, fc, fz, fe, pl);
    vectors++; if (res !== xr) begin miscompares++; $display("FAIL bp_r0: got %h required %h", res, xr); end
  endtask

  task automatic test_random();
    cmd_t c;
    int lat, xl;
    logic [7:0] res, xr;
    logic fc, fz, fe, pl, xe;
    for (int i = 0; i < 30; i++) begin
      c = mk(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom),
             2'($urandom), 8'($urandom), 4'($urandom_range(0, 3)));
      model_cmd(c, xl, xr, xe);
      run_cmd(c, lat, res, fc, fz, fe, pl);
      vectors++; if (lat !== xl) begin miscompares++; $display("FAIL rnd_latency[%0d] op%0d: got %0d required %0d", i, c.op, lat, xl); end
      vectors++; if (fe !== xe) begin miscompares++; $display("FAIL rnd_err[%0d] op%0d: got %b required %b", i, c.op, fe, xe); end
      if (!xe) begin
        vectors++; if (res !== xr) begin miscompares++; $display("FAIL rnd_result[%0d] op%0d: got %h required %h", i, c.op, res, xr); end
      end
      vectors++; if ({fc, fz} !== {m_c[c.u], m_z[c.u]}) begin miscompares++; $display("FAIL rnd_flags[%0d] op%0d: got %b required %b", i, c.op, {fc, fz}, {m_c[c.u], m_z[c.u]}); end
      vectors++; if (pl !== 1'b1) begin miscompares++; $display("FAIL rnd_pulse[%0d]: DoneValid still high next cycle", i); end
    end
  endtask

  task automatic test_reset_mid();
    cmd_t c;
    int lat, xl, n, dones;
    logic [7:0] res, xr;
    logic fc, fz, fe, pl, xe;
    c = mk(0, 3'd4, 2'd1, 2'd0, 2'd0, 8'hC9, 4'd0);
    model_cmd(c, xl, xr, xe);
    run_cmd(c, lat, res, fc, fz, fe, pl);
    @(negedge clk);
    cmd_op[0] = 3'd3; cmd_rd[0] = 2'd0; cmd_ra[0] = 2'd1; cmd_rb[0] = 2'd1;
    cmd_rep[0] = 4'd15; cmd_valid[0] = 1'b1;
    n = 0;
    while (!cmd_ready[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    cmd_valid[0] = 1'b0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done_valid[0]) dones++;
    end
    vectors++; if (busy[0] !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b required 1", busy[0]); end
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    model_reset(0);
    vectors++; if (cmd_ready[0] !== 1'b1) begin miscompares++; $display("FAIL mid_ready: got %b required 1", cmd_ready[0]); end
    vectors++; if (done_valid[0] !== 1'b0) begin miscompares++; $display("FAIL mid_done: got %b required 0", done_valid[0]); end
    vectors++; if ({alu_a[0], alu_b[0], result[0]} !== 24'h0) begin miscompares++; $display("FAIL mid_clear: got %h/%h/%h required 0", alu_a[0], alu_b[0], result[0]); end
    vectors++; if ({flag_c[0], flag_z[0]} !== 2'b00) begin miscompares++; $display("FAIL mid_flags: got %b required 00", {flag_c[0], flag_z[0]}); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_valid[0]) dones++;
    end
    vectors++; if (dones !== 0) begin miscompares++; $display("FAIL mid_no_done: got %0d pulses required 0", dones); end
    for (int r = 0; r < 4; r++) begin
      c = mk(0, 3'd5, 2'd0, 2'(r), 2'd0, 8'h00, 4'd0);
      model_cmd(c, xl, xr, xe);
      run_cmd(c, lat, res, fc, fz, fe, pl);
      vectors++; if (res !== xr) begin miscompares++; $display("FAIL mid_reg r%0d: got %h required %h", r, res, xr); end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; cmd_valid[k] = 1'b0; cmd_op[k] = 3'd0; cmd_rd[k] = 2'd0; cmd_ra[k] = 2'd0;
      cmd_rb[k] = 2'd0; cmd_imm[k] = 8'h00; cmd_rep[k] = 4'd0;
    end
    test_reset();
    test_directed();
    test_csl_trace();
    test_illegal();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
